mul_sequencer: RTL
==================

Name: mul_sequencer

Overview:
- Multi-cycle shift-add sequencer for the EX-stage multiply.
- Started when the ALU decode selects multiply (ALUControl = 3'b101).
- Stalls the pipeline while it iterates and returns the low WIDTH bits of SrcA*SrcB.
- Sits beside the ALU in EX. The hazard unit ORs Stall into the IF/ID/EX freeze, and the EX result mux selects Result when ResultValid is high.

Parameters:
- WIDTH, 32, operand and result width in bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- CLK  input  1  pipeline clock; all state on rising edge.
- RST_n  input  1  asynchronous, active-low reset.
- ALUControl  input  3  EX-stage ALU control; 3'b101 = multiply.
- EXValid  input  1  EX stage holds a real (non-bubble) instruction.
- Flush  input  1  synchronous abort of the EX instruction (branch/exception).
- SrcA  input  WIDTH  multiplicand.
- SrcB  input  WIDTH  multiplier.
- Stall  output  1  freeze IF/ID/EX registers; combinational.
- Busy  output  1  registered; high while in BUSY.
- Result  output  WIDTH  low WIDTH bits of the product; registered.
- ResultValid  output  1  registered; one-cycle pulse, Result is final.

Behaviour:
- Reset: state=IDLE, Busy=0, ResultValid=0, Result=0, internal accumulator/operands/counter=0. Stall=0 while RST_n low.
- Start = EXValid & (ALUControl==3'b101) & ~Flush.
- Stall = (state==IDLE & Start) | (state==BUSY & ~Flush).
- The pipeline freezes in the same cycle the multiply is first seen.

States:
- IDLE:
  - On Start: load mcand=SrcA, mplier=SrcB, acc=0, cnt=0, go BUSY.
  - Otherwise stay.
- BUSY, one iteration per cycle:
  - If mplier[0], acc = acc + mcand (mod 2^WIDTH).
  - mcand <<= 1, mplier >>= 1, cnt += 1.
  - When cnt reaches WIDTH-1 (last iteration this cycle): Result = final acc, ResultValid = 1, go DONE.
- DONE:
  - Stall=0, so the pipeline advances and the multiply leaves EX.
  - Start is ignored here, because the same instruction is still visible in EX.
  - ResultValid drops to 0 and Result holds; go IDLE unconditionally.

Latency:
- Start seen in cycle 0; BUSY for cycles 1..WIDTH; DONE in cycle WIDTH+1.
- Stall is high for cycles 0..WIDTH, i.e. WIDTH+1 cycles.
- A back-to-back multiply is accepted in cycle WIDTH+2.

Arithmetic:
- Unsigned shift-add. The low WIDTH bits are identical for signed operands (MIPS mul semantics).
- Overflow bits are discarded.

Boundary conditions:
- Flush in IDLE: no start.
- Flush in BUSY: abort to IDLE next edge, ResultValid stays 0, Result unchanged, Stall low that cycle.
- Flush in DONE: no effect; the result has already been delivered.
- Operand zero: full iteration count still runs unless the optional feature is enabled.
- SrcA/SrcB changes during BUSY are ignored; operands were latched at start.
- RST_n low mid-operation: immediate return to the reset values; no ResultValid.

Optional Feature:
- Macro: MUL_EARLY_TERM_EN.
- Defined: in BUSY, if the shifted mplier value after this iteration is 0, the iteration is treated as last. Result and ResultValid are set and the state goes to DONE, so latency is (index of highest set bit of SrcB)+1 BUSY cycles. SrcB=0 takes exactly 1 BUSY cycle with Result=0.
- Undefined: fixed WIDTH BUSY cycles.
- The result value is identical in both builds.

Test Plan:
- WIDTH=32, SrcA=3, SrcB=5, ALUControl=101, EXValid=1 -> Stall high 33 cycles, ResultValid pulse in cycle 33, Result=15.
- SrcA=0xFFFFFFFF, SrcB=2 -> Result=0xFFFFFFFE; SrcA=0x80000000, SrcB=0x80000000 -> Result=0.
- Start, then Flush=1 in BUSY cycle 10 -> IDLE next edge, Stall low in cycle 10, no ResultValid, Result keeps its prior value.
- RST_n low in BUSY cycle 5, released 2 cycles later -> all outputs 0; a new multiply 7*6 gives 42.
- Two consecutive multiplies (ALUControl held 101 through DONE) -> second accepted only in cycle 34; Results 3*5=15 then 4*4=16; exactly two ResultValid pulses.
- With MUL_EARLY_TERM_EN: 7*3 -> 2 BUSY cycles, Stall high 3 cycles, Result=21. 9*0 -> 1 BUSY cycle, Result=0. Without the macro both take 32 BUSY cycles.

Source files
------------

// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - multi-cycle shift-add multiply sequencer for the EX stage
// Optional early termination on an exhausted multiplier: define MUL_EARLY_TERM_EN.
`timescale 1ns/1ps

module mul_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [2:0]       ALUControl,
  input  logic             EXValid,
  input  logic             Flush,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Stall,
  output logic             Busy,
  output logic [WIDTH-1:0] Result,
  output logic             ResultValid
);

  localparam logic [2:0]       ALU_MUL  = 3'b101;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;

  logic               start;
  logic               stall_c;
  logic               last_iter;
  logic [WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]   mplier_shift;

  assign start        = EXValid & (ALUControl == ALU_MUL) & ~Flush;
  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;

`ifdef MUL_EARLY_TERM_EN
  // Once no multiplier bits remain, further iterations cannot change acc.
  assign last_iter = (cnt_q == LAST_CNT) || (mplier_shift == '0);
`else
  assign last_iter = (cnt_q == LAST_CNT);
`endif

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = 1'b0;
    stall_c  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          stall_c  = 1'b1;
          mcand_d  = SrcA;
          mplier_d = SrcB;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end
      end
      S_BUSY: begin
        if (Flush) begin
          state_d = S_IDLE;
        end else begin
          stall_c  = 1'b1;
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_shift;
          cnt_d    = cnt_q + CNT_W'(1);
          if (last_iter) begin
            result_d = acc_sum;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      // The multiply is still visible in EX here, so a new start is ignored.
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign Stall       = RST_n & stall_c;
  assign Busy        = (state_q == S_BUSY);
  assign Result      = result_q;
  assign ResultValid = valid_q;

endmodule
